sx_bus_initiator: RTL and testbench
===================================

// Module: sx_bus_initiator
// PURPOSE
//  Bus-cycle initiator for the 80386SX local bus: the requesting end of the protocol the southbridge answers.
//  Takes single-transfer requests on a valid/ready interface and drives ADS#, status, byte enables, address and write data.
//  Waits for READY#, then returns read data or completion on a one-cycle response strobe.
//  Used as a bus exerciser/DMA front end on the same bus as the CPU; one T-state per clk, non-pipelined (NA# ignored).
// PARAMETERS
//  TIMEOUT_CYCLES  255  T2 cycles allowed before forced termination (only with BUS_TIMEOUT_EN); range 1..2^CNT_W-1
//  CNT_W           8    width of wait-state counter and last_wait
// PORTS
//  clk          in   1   bus clock, one T-state per rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   request accepted when req_valid & req_ready at posedge
//  req_addr     in   23  word address [23:1]
//  req_wr       in   1   1=write, 0=read
//  req_mio      in   1   1=memory, 0=I/O
//  req_dc       in   1   1=data, 0=control
//  req_be_n     in   2   byte enables {BHE#,BLE#}, active low; 2'b11 illegal (see below)
//  req_wdata    in   16  write data
//  rsp_valid    out  1   one-cycle completion strobe
//  rsp_rdata    out  16  read data, valid with rsp_valid (0 for writes)
//  rsp_err      out  1   completion was a timeout (0 without BUS_TIMEOUT_EN)
//  last_wait    out  CNT_W  T2 cycles used by the last completed transfer
//  ads_n        out  1   address strobe, active low
//  bus_wr/bus_mio/bus_dc  out 1 each  cycle definition
//  bus_be_n     out  2   byte enables to bus
//  bus_addr     out  23  address [23:1]
//  addr_oe      out  1   address/status/BE output enable
//  bus_dout     out  16  write data
//  data_oe      out  1   data output enable
//  bus_din      in   16  read data from bus
//  ready_n      in   1   READY#, active low, sampled in T2 only
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1, ads_n=1, addr_oe=0, data_oe=0, rsp_valid=0, rsp_err=0, rsp_rdata=0,
//   bus_be_n=2'b11, bus_addr=0, bus_wr/mio/dc=0, bus_dout=0, last_wait=0, wait counter=0.
//  States: IDLE -> T1 -> T2 (repeat) -> IDLE. All outputs registered.
//  IDLE: req_ready=1. On req_valid: latch request, req_ready=0 next cycle, enter T1.
//   req_be_n==2'b11 is treated as 2'b00 (word); never issue a cycle with no lanes enabled.
//  T1 (exactly 1 clk): ads_n=0, addr_oe=1, address/status/BE driven from latched request, data_oe=0.
//  T2: ads_n=1; address/status/BE held stable; data_oe=1 for writes (first T2 through last T2), 0 for reads.
//   Each T2 clk: wait counter increments (saturates at 2^CNT_W-1); ready_n sampled at posedge.
//   ready_n=0: capture bus_din into rsp_rdata (reads; writes load 0), rsp_valid=1 for one cycle,
//   last_wait=T2 count incl. this one (min 1), go IDLE, addr_oe=0, data_oe=0 same edge.
//  ready_n ignored in IDLE and T1; a stray READY# there has no effect.
//  Latency: accept edge -> T1 -> T2; min 3 clks accept-to-rsp_valid; next accept no earlier than cycle after rsp_valid.
//  req_ready rises with rsp_valid; back-to-back gives one IDLE clk between cycles (ads_n high >=2 clks).
//  Request inputs changing after acceptance have no effect.
//  Async reset mid-cycle: immediate return to reset values, bus released, no rsp_valid for aborted transfer.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: if TIMEOUT_CYCLES T2 clks pass with ready_n=1, end cycle on that edge:
//   rsp_valid=1, rsp_err=1, rsp_rdata=16'hFFFF, last_wait=TIMEOUT_CYCLES, go IDLE.
//   If ready_n=0 on the same edge, normal completion wins (rsp_err=0).
//  BUS_TIMEOUT_EN undefined: waits indefinitely in T2; rsp_err tied 0; no timeout logic.
// TESTING
//  Read 0xFFFFF0>>1, be_n=00, ready_n=0 at 1st T2, din=16'hFEEB -> ads_n low 1 clk, rsp_rdata=FEEB, last_wait=1.
//  Write I/O addr 0x80>>1, wdata=16'h55AA, ready_n low at 4th T2 -> data_oe 4 clks, bus_dout=55AA, last_wait=4.
//  Two requests held valid back-to-back -> ads_n pulses 3 clks apart, req_ready low during each cycle.
//  ready_n=0 pulsed during IDLE and T1 only, then at 2nd T2 -> no early completion, last_wait=2.
//  reset_n low during 3rd T2 of a write -> addr_oe/data_oe 0 immediately, no rsp_valid, next request normal.
//  BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready_n held 1 -> rsp_err=1, rsp_rdata=FFFF, last_wait=8 on 8th T2.

Source files
------------

// File: rtl/sx_bus_initiator.sv
// 80386SX local-bus cycle initiator: valid/ready request in, ADS#/READY# bus cycle out.
// Optional T2 timeout via BUS_TIMEOUT_EN (TIMEOUT_CYCLES, CNT_W).
module sx_bus_initiator #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [22:0]      req_addr,
   input  logic             req_wr,
   input  logic             req_mio,
   input  logic             req_dc,
   input  logic [1:0]       req_be_n,
   input  logic [15:0]      req_wdata,
   output logic             rsp_valid,
   output logic [15:0]      rsp_rdata,
   output logic             rsp_err,
   output logic [CNT_W-1:0] last_wait,
   output logic             ads_n,
   output logic             bus_wr,
   output logic             bus_mio,
   output logic             bus_dc,
   output logic [1:0]       bus_be_n,
   output logic [22:0]      bus_addr,
   output logic             addr_oe,
   output logic [15:0]      bus_dout,
   output logic             data_oe,
   input  logic [15:0]      bus_din,
   input  logic             ready_n
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_T1   = 2'd1,
      S_T2   = 2'd2
   } state_t;

   state_t           r_state, w_state_nx;
   logic             r_req_ready, w_req_ready;
   logic             r_ads_n, w_ads_n;
   logic             r_addr_oe, w_addr_oe;
   logic             r_data_oe, w_data_oe;
   logic             r_rsp_valid, w_rsp_valid;
   logic [15:0]      r_rsp_rdata, w_rsp_rdata;
   logic [CNT_W-1:0] r_last_wait, w_last_wait;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic             r_bus_wr, w_bus_wr;
   logic             r_bus_mio, w_bus_mio;
   logic             r_bus_dc, w_bus_dc;
   logic [1:0]       r_bus_be_n, w_bus_be_n;
   logic [22:0]      r_bus_addr, w_bus_addr;
   logic [15:0]      r_bus_dout, w_bus_dout;

   logic             w_accept;
   logic             w_done_ok;
   logic             w_tmo;
   logic             w_done;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [1:0]       w_be_sel;

   assign w_accept  = (r_state == S_IDLE) & req_valid & r_req_ready;
   assign w_done_ok = (r_state == S_T2) & ~ready_n;
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
   // An all-disabled BE pattern would be a dead cycle; promote it to a word
   assign w_be_sel  = (req_be_n == 2'b11) ? 2'b00 : req_be_n;

`ifdef BUS_TIMEOUT_EN
   logic r_rsp_err, w_rsp_err;
   assign w_tmo = (r_state == S_T2) & ready_n &
                  (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
   assign rsp_err = r_rsp_err;
`else
   assign w_tmo   = 1'b0;
   assign rsp_err = 1'b0;
`endif

   assign w_done = w_done_ok | w_tmo;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b1;
         r_ads_n     <= 1'b1;
         r_addr_oe   <= 1'b0;
         r_data_oe   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_last_wait <= '0;
         r_cnt       <= '0;
         r_bus_wr    <= 1'b0;
         r_bus_mio   <= 1'b0;
         r_bus_dc    <= 1'b0;
         r_bus_be_n  <= 2'b11;
         r_bus_addr  <= '0;
         r_bus_dout  <= '0;
`ifdef BUS_TIMEOUT_EN
         r_rsp_err   <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nx;
         r_req_ready <= w_req_ready;
         r_ads_n     <= w_ads_n;
         r_addr_oe   <= w_addr_oe;
         r_data_oe   <= w_data_oe;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_rdata <= w_rsp_rdata;
         r_last_wait <= w_last_wait;
         r_cnt       <= w_cnt;
         r_bus_wr    <= w_bus_wr;
         r_bus_mio   <= w_bus_mio;
         r_bus_dc    <= w_bus_dc;
         r_bus_be_n  <= w_bus_be_n;
         r_bus_addr  <= w_bus_addr;
         r_bus_dout  <= w_bus_dout;
`ifdef BUS_TIMEOUT_EN
         r_rsp_err   <= w_rsp_err;
`endif
      end
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_state_nx = S_T1;
         S_T1:    w_state_nx = S_T2;
         S_T2:    if (w_done) w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      w_req_ready = r_req_ready;
      w_ads_n     = r_ads_n;
      w_addr_oe   = r_addr_oe;
      w_data_oe   = r_data_oe;
      w_rsp_valid = 1'b0;
      w_rsp_rdata = r_rsp_rdata;
      w_last_wait = r_last_wait;
      w_cnt       = r_cnt;
      w_bus_wr    = r_bus_wr;
      w_bus_mio   = r_bus_mio;
      w_bus_dc    = r_bus_dc;
      w_bus_be_n  = r_bus_be_n;
      w_bus_addr  = r_bus_addr;
      w_bus_dout  = r_bus_dout;
`ifdef BUS_TIMEOUT_EN
      w_rsp_err   = r_rsp_err;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_req_ready = 1'b0;
               w_ads_n     = 1'b0;
               w_addr_oe   = 1'b1;
               w_cnt       = '0;
               w_bus_wr    = req_wr;
               w_bus_mio   = req_mio;
               w_bus_dc    = req_dc;
               w_bus_be_n  = w_be_sel;
               w_bus_addr  = req_addr;
               w_bus_dout  = req_wdata;
            end
         end
         S_T1: begin
            w_ads_n   = 1'b1;
            w_data_oe = r_bus_wr;
         end
         S_T2: begin
            w_cnt = w_cnt_inc;
            if (w_done) begin
               w_rsp_valid = 1'b1;
               w_req_ready = 1'b1;
               w_addr_oe   = 1'b0;
               w_data_oe   = 1'b0;
               w_last_wait = w_cnt_inc;
               // READY# on the timeout edge still counts as a normal finish
               if (w_done_ok)
                  w_rsp_rdata = r_bus_wr ? 16'h0000 : bus_din;
               else
                  w_rsp_rdata = 16'hFFFF;
`ifdef BUS_TIMEOUT_EN
               w_rsp_err = ~w_done_ok;
`endif
            end
         end
         default: ;
      endcase
   end

   assign req_ready = r_req_ready;
   assign ads_n     = r_ads_n;
   assign addr_oe   = r_addr_oe;
   assign data_oe   = r_data_oe;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign last_wait = r_last_wait;
   assign bus_wr    = r_bus_wr;
   assign bus_mio   = r_bus_mio;
   assign bus_dc    = r_bus_dc;
   assign bus_be_n  = r_bus_be_n;
   assign bus_addr  = r_bus_addr;
   assign bus_dout  = r_bus_dout;

endmodule

// File: tb/tb_sx_bus_initiator.sv
// Bench for sx_bus_initiator: transaction-timeline model, per-cycle compare.
module tb_sx_bus_initiator;

`ifdef BUS_TIMEOUT_EN
   localparam int TO    = 8;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO    = 255;
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [22:0] req_addr;
   logic        req_wr, req_mio, req_dc;
   logic [1:0]  req_be_n;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic [7:0]  last_wait;
   logic        ads_n;
   logic        bus_wr, bus_mio, bus_dc;
   logic [1:0]  bus_be_n;
   logic [22:0] bus_addr;
   logic        addr_oe;
   logic [15:0] bus_dout;
   logic        data_oe;
   logic [15:0] bus_din;
   logic        ready_n;

   sx_bus_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wr(req_wr), .req_mio(req_mio),
      .req_dc(req_dc), .req_be_n(req_be_n), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .last_wait(last_wait), .ads_n(ads_n),
      .bus_wr(bus_wr), .bus_mio(bus_mio), .bus_dc(bus_dc),
      .bus_be_n(bus_be_n), .bus_addr(bus_addr), .addr_oe(addr_oe),
      .bus_dout(bus_dout), .data_oe(data_oe),
      .bus_din(bus_din), .ready_n(ready_n)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Current transaction as the model sees it: accept cycle plus its fields
   bit          tx_valid = 1'b0;
   int          tx_a, tx_we;
   logic [22:0] tx_addr;
   logic        tx_wr, tx_mio, tx_dc, tx_err;
   logic [1:0]  tx_be;
   logic [15:0] tx_wd, tx_rd;
   int          prev_last = 0;
   int          cur_last  = 0;

   int          ads_cnt = 0, ads_last = 0, ads_prev = 0;
   int          doe_cnt = 0;
   logic [15:0] dout_seen = 16'h0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      int ph, d, exp_last;
      if (!reset_n) begin
         chk("rst_req_ready", req_ready, 1);
         chk("rst_ads_n", ads_n, 1);
         chk("rst_addr_oe", addr_oe, 0);
         chk("rst_data_oe", data_oe, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_err", rsp_err, 0);
         chk("rst_rdata", rsp_rdata, 0);
         chk("rst_last_wait", last_wait, 0);
         chk("rst_be_n", bus_be_n, 2'b11);
         chk("rst_addr", bus_addr, 0);
         chk("rst_status", {bus_wr, bus_mio, bus_dc}, 0);
         chk("rst_dout", bus_dout, 0);
      end else begin
         d  = tx_valid ? cyc - tx_a : -1;
         // 0 idle, 1 T1, 2 T2, 3 response cycle
         if (!tx_valid || d > tx_we + 1) ph = 0;
         else if (d == 0)                ph = 1;
         else if (d <= tx_we)            ph = 2;
         else                            ph = 3;
         exp_last = (tx_valid && d >= tx_we + 1) ? tx_we : prev_last;
         chk("req_ready", req_ready, (ph == 0 || ph == 3) ? 1 : 0);
         chk("ads_n", ads_n, (ph == 1) ? 0 : 1);
         chk("addr_oe", addr_oe, (ph == 1 || ph == 2) ? 1 : 0);
         chk("data_oe", data_oe, (ph == 2 && tx_wr) ? 1 : 0);
         chk("rsp_valid", rsp_valid, (ph == 3) ? 1 : 0);
         chk("last_wait", last_wait, exp_last);
         if (ph == 1 || ph == 2) begin
            chk("bus_addr", bus_addr, tx_addr);
            chk("bus_be_n", bus_be_n, tx_be);
            chk("bus_stat", {bus_wr, bus_mio, bus_dc},
                {tx_wr, tx_mio, tx_dc});
         end
         if (ph == 2 && tx_wr) chk("bus_dout", bus_dout, tx_wd);
         if (ph == 3) begin
            chk("rsp_rdata", rsp_rdata, tx_rd);
            chk("rsp_err", rsp_err, tx_err);
         end
      end
      if (ads_n === 1'b0) begin
         ads_cnt++;
         ads_prev = ads_last;
         ads_last = cyc;
      end
      if (data_oe === 1'b1) begin
         doe_cnt++;
         dout_seen = bus_dout;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble(input logic v);
      req_valid = v;
      req_addr  = 23'($urandom);
      req_wr    = 1'($urandom);
      req_mio   = 1'($urandom);
      req_dc    = 1'($urandom);
      req_be_n  = 2'($urandom);
      req_wdata = 16'($urandom);
   endtask

   task automatic idle(input int n, input int rn);
      repeat (n) begin
         step();
         scramble(1'b0);
         ready_n = (rn == 2) ? 1'($urandom) : rn[0];
         bus_din = 16'($urandom);
      end
   endtask

   // Caller guarantees the current cycle is idle for the model
   task automatic start_tx(input logic [22:0] a, input logic wr,
                           input logic mio, input logic dc,
                           input logic [1:0] be, input logic [15:0] wd,
                           input logic [15:0] din, input int w,
                           input int t1_rn, input int rst_at);
      req_addr = a; req_wr = wr; req_mio = mio; req_dc = dc;
      req_be_n = be; req_wdata = wd; req_valid = 1'b1;
      step();
      tx_a = cyc; tx_addr = a; tx_wr = wr; tx_mio = mio; tx_dc = dc;
      tx_be = (be == 2'b11) ? 2'b00 : be;
      tx_wd = wd;
      prev_last = cur_last;
      if (TO_EN && w > TO) begin tx_we = TO; tx_err = 1'b1; end
      else begin tx_we = w; tx_err = 1'b0; end
      tx_rd = tx_err ? 16'hFFFF : (wr ? 16'h0000 : din);
      tx_valid = 1'b1;
      scramble(1'($urandom));
      ready_n = (t1_rn == 2) ? 1'($urandom) : t1_rn[0];
      bus_din = 16'($urandom);
      for (int d = 1; d <= tx_we; d++) begin
         step();
         if (d == rst_at) begin
            #2;
            reset_n = 1'b0;
            tx_valid = 1'b0; cur_last = 0; prev_last = 0;
            req_valid = 1'b0;
            #1;
            chk("arst_addr_oe", addr_oe, 0);
            chk("arst_data_oe", data_oe, 0);
            chk("arst_ads_n", ads_n, 1);
            chk("arst_rsp_valid", rsp_valid, 0);
            return;
         end
         scramble(1'($urandom));
         ready_n = (d == w) ? 1'b0 : 1'b1;
         bus_din = (d == w) ? din : 16'($urandom);
      end
      step();
      cur_last = tx_we;
      req_valid = 1'b0;
      ready_n = 1'($urandom);
      bus_din = 16'($urandom);
   endtask

   int base;

   initial begin
      reset_n = 1'b1;
      scramble(1'b0);
      ready_n = 1'b1;
      bus_din = 16'h0;
      #2 reset_n = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      idle(2, 2);

      // read at top of memory, zero wait
      base = ads_cnt;
      start_tx(23'h7FFFF8, 0, 1, 1, 2'b00, 16'h1234, 16'hFEEB, 1, 1, 0);
      chk("lit_rd_valid", rsp_valid, 1);
      chk("lit_rd_data", rsp_rdata, 16'hFEEB);
      chk("lit_rd_wait", last_wait, 1);
      chk("lit_rd_ads", ads_cnt - base, 1);
      idle(1, 1);

      // I/O write, READY# at 4th T2
      base = doe_cnt;
      start_tx(23'h000040, 1, 0, 1, 2'b00, 16'h55AA, 16'h0, 4, 1, 0);
      chk("lit_wr_doe", doe_cnt - base, 4);
      chk("lit_wr_dout", dout_seen, 16'h55AA);
      chk("lit_wr_wait", last_wait, 4);
      chk("lit_wr_rdata", rsp_rdata, 0);

      // back-to-back with request held valid
      start_tx(23'h001000, 0, 1, 1, 2'b01, 16'h0, 16'hA5A5, 1, 2, 0);
      start_tx(23'h001001, 0, 1, 1, 2'b10, 16'h0, 16'h5A5A, 1, 2, 0);
      chk("lit_b2b_gap", ads_last - ads_prev, 3);
      chk("lit_b2b_data", rsp_rdata, 16'h5A5A);

      // stray READY# in IDLE and T1, real one at 2nd T2
      idle(2, 0);
      start_tx(23'h002222, 0, 1, 0, 2'b11, 16'h0, 16'hC0DE, 2, 0, 0);
      chk("lit_stray_wait", last_wait, 2);
      chk("lit_stray_data", rsp_rdata, 16'hC0DE);

      // async reset in the 3rd T2 of a write
      idle(1, 1);
      start_tx(23'h003333, 1, 1, 1, 2'b00, 16'hBEEF, 16'h0, 6, 1, 3);
      step();
      step();
      reset_n = 1'b1;
      ready_n = 1'b1;
      start_tx(23'h004444, 0, 1, 1, 2'b00, 16'h0, 16'h1111, 2, 1, 0);
      chk("lit_post_rst", rsp_rdata, 16'h1111);

`ifdef BUS_TIMEOUT_EN
      idle(1, 1);
      start_tx(23'h005555, 0, 1, 1, 2'b00, 16'h0, 16'h2222, 20, 1, 0);
      chk("lit_tmo_err", rsp_err, 1);
      chk("lit_tmo_data", rsp_rdata, 16'hFFFF);
      chk("lit_tmo_wait", last_wait, 8);
      start_tx(23'h005556, 0, 1, 1, 2'b00, 16'h0, 16'h3333, 8, 1, 0);
      chk("lit_tmo_edge_err", rsp_err, 0);
      chk("lit_tmo_edge_data", rsp_rdata, 16'h3333);
`endif

      for (int i = 0; i < 60; i++) begin
         int g;
         start_tx(23'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 2'($urandom), 16'($urandom),
                  16'($urandom), $urandom_range(1, TO_EN ? 12 : 6),
                  2, 0);
         g = $urandom_range(0, 2);
         if (g > 0) idle(g, 2);
      end
      idle(3, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
